// File: rtl/axis_arb_pkg.sv
// Shared types and the rotate-priority selection helper for the AXI-Stream
// round-robin arbiter.
package axis_arb_pkg;

    localparam int MAX_INPUTS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // One-hot pick of the first set request at or after ptr, wrapping at n.
    function automatic logic [MAX_INPUTS-1:0] rr_onehot(
        input logic [MAX_INPUTS-1:0] req,
        input int unsigned           ptr,
        input int unsigned           n
    );
        logic [MAX_INPUTS-1:0] gnt;
        logic                  found;
        int unsigned           c;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
            c = ptr + k;
            if (c >= n) begin
                c = c - n;
            end
            if ((k < n) && !found && req[c[3:0]]) begin
                gnt[c[3:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_select.sv
// Combinational round-robin selector: one-hot grant and its index for the
// first eligible requester at or after the priority pointer.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [NUM_INPUTS-1:0] gnt_o,
    output logic [IDX_W-1:0]      idx_o
);

    logic [MAX_INPUTS-1:0] req_pad;

    always_comb begin
        req_pad                 = '0;
        req_pad[NUM_INPUTS-1:0] = req_i;
    end

    assign gnt_o = NUM_INPUTS'(rr_onehot(req_pad, 32'(ptr_i), NUM_INPUTS));

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (gnt_o[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin AXI-Stream arbiter: holds a grant for a whole
// packet (or a fixed beat budget) and drives one registered output stage.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int TLAST_EN   = 1,
    parameter  int MAX_BURST  = 16,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [NUM_INPUTS-1:0] mask_i,
    input  logic [NUM_INPUTS-1:0] s_tvalid_i,
    input  logic [DATA_WIDTH-1:0] s_tdata_i [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] s_tlast_i,
    output logic [NUM_INPUTS-1:0] s_tready_o,
    output logic                  m_tvalid_o,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tlast_o,
    output logic [IDX_W-1:0]      m_tid_o,
    input  logic                  m_tready_i,
    output logic [NUM_INPUTS-1:0] grant_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q;
    logic [NUM_INPUTS-1:0] gnt_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  m_tvalid_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  m_tlast_q;
    logic [IDX_W-1:0]      m_tid_q;

    logic [NUM_INPUTS-1:0] eligible;
    logic [NUM_INPUTS-1:0] sel_gnt;
    logic [IDX_W-1:0]      sel_idx;
    logic                  out_free;
    logic                  beat_acc;
    logic                  beat_last;
    logic                  budget_end;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    assign eligible = s_tvalid_i & mask_i;

    rr_select #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_select (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx)
    );

    // Ready depends only on grant state and the output register, never on
    // s_tvalid_i; it is also held low during reset so no beat is consumed
    // by a packet that is being discarded.
    assign out_free   = ~m_tvalid_q | m_tready_i;
    assign s_tready_o = (rst_i && (state_q == ST_BUSY) && out_free) ? gnt_q : '0;

    assign sel_data   = s_tdata_i[gnt_idx_q];
    assign sel_last   = s_tlast_i[gnt_idx_q];
    assign beat_acc   = |(s_tready_o & s_tvalid_i);

    assign budget_end = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign beat_last  = (TLAST_EN != 0) ? sel_last : budget_end;
    assign cnt_d      = cnt_q + CNT_W'(1);
    assign ptr_d      = (gnt_idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            // Output register: a newly accepted beat wins over a pop.
            if (beat_acc) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= sel_data;
                m_tlast_q  <= beat_last;
                m_tid_q    <= gnt_idx_q;
            end else if (m_tready_i) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en_i && (|eligible)) begin
                        gnt_q     <= sel_gnt;
                        gnt_idx_q <= sel_idx;
                        cnt_q     <= '0;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat_acc) begin
                        cnt_q <= cnt_d;
                        if (beat_last) begin
                            ptr_q   <= ptr_d;
                            gnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_tvalid_o = m_tvalid_q;
    assign m_tdata_o  = m_tdata_q;
    assign m_tlast_o  = m_tlast_q;
    assign m_tid_o    = m_tid_q;
    assign grant_o    = gnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a cycle table for arbitration, masking
// and enable, plus sequences for backpressure, mid-packet reset and budget mode.
module tb_axis_rr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic [3:0]  mask;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data [4];
    logic [3:0]  rdy;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic [1:0]  mid;
    logic        tr;
    logic [3:0]  gnt;

    logic        b_en;
    logic [3:0]  b_mask;
    logic [3:0]  b_valid;
    logic [3:0]  b_last;
    logic [31:0] b_data [4];
    logic [3:0]  b_rdy;
    logic        b_mv;
    logic [31:0] b_md;
    logic        b_ml;
    logic [1:0]  b_mid;
    logic        b_tr;
    logic [3:0]  b_gnt;

    axis_rr_arbiter #(
        .NUM_INPUTS (4), .DATA_WIDTH (32), .TLAST_EN (1), .MAX_BURST (16)
    ) u_dut (
        .clk_i (clk), .rst_i (rst_n), .en_i (en), .mask_i (mask),
        .s_tvalid_i (valid), .s_tdata_i (data), .s_tlast_i (last), .s_tready_o (rdy),
        .m_tvalid_o (mv), .m_tdata_o (md), .m_tlast_o (ml), .m_tid_o (mid),
        .m_tready_i (tr), .grant_o (gnt)
    );

    axis_rr_arbiter #(
        .NUM_INPUTS (4), .DATA_WIDTH (32), .TLAST_EN (0), .MAX_BURST (4)
    ) u_bud (
        .clk_i (clk), .rst_i (rst_n), .en_i (b_en), .mask_i (b_mask),
        .s_tvalid_i (b_valid), .s_tdata_i (b_data), .s_tlast_i (b_last), .s_tready_o (b_rdy),
        .m_tvalid_o (b_mv), .m_tdata_o (b_md), .m_tlast_o (b_ml), .m_tid_o (b_mid),
        .m_tready_i (b_tr), .grant_o (b_gnt)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic [3:0] valid;
        logic [3:0] last;
        logic       tr;
        logic [3:0] e_rdy;
        logic [3:0] e_gnt;
        logic       e_mv;
        logic [1:0] e_tid;
        logic       e_last;
    } vec_t;

    vec_t tbl [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] mk, input logic [3:0] v,
                       input logic [3:0] l, input logic t, input logic [3:0] er,
                       input logic [3:0] eg, input logic em, input logic [1:0] et, input logic el);
        vec_t x;
        x.rst = r; x.en = e; x.mask = mk; x.valid = v; x.last = l; x.tr = t;
        x.e_rdy = er; x.e_gnt = eg; x.e_mv = em; x.e_tid = et; x.e_last = el;
        tbl.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid = 4'h0; last = 4'h0; b_valid = 4'h0; tr = 1'b1; en = 1'b1; mask = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oseq [4];
        int seq  [4];
        int cur;
        int got;
        int first;
        int ob;
        int bseq;

        rst_n = 1'b0; en = 1'b1; mask = 4'hF; valid = 4'h0; last = 4'h0; tr = 1'b1;
        b_en = 1'b1; b_mask = 4'hF; b_valid = 4'h0; b_last = 4'h0; b_tr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data[i]   = '0;
            b_data[i] = '0;
        end

        //   rst   en    mask   valid  last   tr  | rdy    gnt    mv    tid    last
        add(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h1, 1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h2, 1'b0, 2'd0, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h2, 1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h4, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h4, 4'h4, 1'b1, 2'd2, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h4, 1'b1, 4'h4, 4'h0, 1'b1, 2'd2, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h8, 1'b0, 2'd2, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1, 2'd3, 1'b0);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd3, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'hF, 4'h1, 1'b1, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1);
        add(1'b1, 1'b1, 4'hA, 4'hF, 4'h0, 1'b1, 4'h0, 4'h2, 1'b0, 2'd0, 1'b1);
        add(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b0, 4'h0, 4'hF, 4'h2, 1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 1'b1);
        add(1'b1, 1'b0, 4'hA, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b0, 4'hA, 4'hF, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hA, 4'hF, 4'h0, 1'b1, 4'h0, 4'h8, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hA, 4'hF, 4'h8, 1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1);
        add(1'b1, 1'b1, 4'hA, 4'hF, 4'h0, 1'b1, 4'h0, 4'h2, 1'b0, 2'd3, 1'b1);
        add(1'b1, 1'b1, 4'hA, 4'hF, 4'h2, 1'b1, 4'h2, 4'h0, 1'b1, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'h1, 4'h0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd1, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'h1, 4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1);
        add(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst_n = tbl[k].rst; en = tbl[k].en; mask = tbl[k].mask;
            valid = tbl[k].valid; last = tbl[k].last; tr = tbl[k].tr;
            for (int i = 0; i < 4; i++) data[i] = {8'(i), 24'(k)};
            #1;
            check($sformatf("v%0d.s_tready", k), 32'(rdy), 32'(tbl[k].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.grant", k), 32'(gnt), 32'(tbl[k].e_gnt));
            check($sformatf("v%0d.m_tvalid", k), 32'(mv), 32'(tbl[k].e_mv));
            check($sformatf("v%0d.m_tid", k), 32'(mid), 32'(tbl[k].e_tid));
            check($sformatf("v%0d.m_tlast", k), 32'(ml), 32'(tbl[k].e_last));
        end

        // Two 5-beat packets each from inputs 1 and 2 under random backpressure.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            oseq[i] = 0;
            seq[i]  = 0;
        end
        cur = -1;
        got = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            valid = 4'h0;
            last  = 4'h0;
            for (int i = 1; i <= 2; i++) begin
                valid[i] = (seq[i] < 10);
                last[i]  = ((seq[i] % 5) == 4);
                data[i]  = {8'(i), 24'(seq[i])};
            end
            tr = 1'($urandom_range(0, 1));
            #1;
            if (mv && tr) begin
                if (cur >= 0) check("bp.contiguous_tid", 32'(mid), 32'(cur));
                check("bp.data", md, {8'(mid), 24'(oseq[mid])});
                check("bp.tlast", 32'(ml), 32'((oseq[mid] % 5) == 4));
                cur = ((oseq[mid] % 5) == 4) ? -1 : int'(mid);
                oseq[mid]++;
                got++;
            end
            for (int i = 1; i <= 2; i++) begin
                if (valid[i] && rdy[i]) seq[i]++;
            end
            @(posedge clk);
        end
        check("bp.beat_count", 32'(got), 32'd20);

        // Reset during the third beat of a packet from input 2.
        do_reset();
        valid = 4'b0100; last = 4'h0; tr = 1'b1; data[2] = 32'h0200_0000;
        @(posedge clk);
        #1;
        check("rst.grant_in2", 32'(gnt), 32'h4);
        @(negedge clk);
        data[2] = 32'h0200_0000;
        @(posedge clk);
        #1;
        check("rst.beat0_valid", 32'(mv), 32'h1);
        check("rst.beat0_data", md, 32'h0200_0000);
        @(negedge clk);
        data[2] = 32'h0200_0001;
        @(posedge clk);
        #1;
        check("rst.beat1_data", md, 32'h0200_0001);
        @(negedge clk);
        rst_n = 1'b0; data[2] = 32'h0200_0002;
        #1;
        check("rst.s_tready_in_reset", 32'(rdy), 32'h0);
        @(posedge clk);
        #1;
        check("rst.m_tvalid", 32'(mv), 32'h0);
        check("rst.grant", 32'(gnt), 32'h0);
        check("rst.m_tdata", md, 32'h0);
        check("rst.m_tid", 32'(mid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; valid = 4'hF;
        @(posedge clk);
        #1;
        check("rst.restart_from_0", 32'(gnt), 32'h1);

        // Budget mode: input 0 streams 10 beats, grants of 4 beats each.
        do_reset();
        first = -1;
        ob    = 0;
        bseq  = 0;
        for (int cyc = 0; cyc < 100 && ob < 10; cyc++) begin
            @(negedge clk);
            b_valid   = (bseq < 10) ? 4'h1 : 4'h0;
            b_data[0] = 32'(bseq);
            b_tr      = 1'b1;
            #1;
            if (b_mv) begin
                if (first < 0) first = cyc;
                check($sformatf("bud.b%0d_data", ob), b_md, 32'(ob));
                check($sformatf("bud.b%0d_tlast", ob), 32'(b_ml), 32'((ob % 4) == 3));
                check($sformatf("bud.b%0d_tid", ob), 32'(b_mid), 32'h0);
                check($sformatf("bud.b%0d_cycle", ob), 32'(cyc - first), 32'(ob + ob / 4));
                ob++;
            end
            if (b_valid[0] && b_rdy[0]) bseq++;
            @(posedge clk);
        end
        check("bud.beat_count", 32'(ob), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
